// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column drive, 2-flop row sync, frame debounce and
// a press/release FSM that emits one key_valid strobe per accepted new key.
module keypad_scanner #(
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  output logic [11:0] key_data,
  output logic        key_valid,
  output logic        o_fsm_state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_SCANS);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESSED = 1'b1
  } state_t;

  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_col_idx;
  logic [2:0]    r_col;
  logic [11:0]   r_raw;
  logic [11:0]   r_prev;
  logic [11:0]   r_deb;
  logic [CW-1:0] r_stable_cnt;
  logic          r_deb_upd;
  state_t        r_state;
  logic [11:0]   r_key_data;
  logic          r_key_valid;

  logic          w_col_end;
  logic          w_frame_end;
  logic [11:0]   w_frame;
  logic [CW-1:0] w_cnt_next;
  logic          w_onehot;

  assign w_col_end   = (r_div == DIV_LAST);
  assign w_frame_end = w_col_end && (r_col_idx == 2'd2);
  assign w_onehot    = (r_deb != 12'd0) && ((r_deb & (r_deb - 12'd1)) == 12'd0);

  // Key n = 3r+c+1 lives in bit 12-n, so column c owns bits 11-c, 8-c, 5-c, 2-c.
  always_comb begin
    w_frame = r_raw;
    if (w_col_end) begin
      case (r_col_idx)
        2'd0:    {w_frame[11], w_frame[8], w_frame[5], w_frame[2]} =
                   {r_sync2[0], r_sync2[1], r_sync2[2], r_sync2[3]};
        2'd1:    {w_frame[10], w_frame[7], w_frame[4], w_frame[1]} =
                   {r_sync2[0], r_sync2[1], r_sync2[2], r_sync2[3]};
        2'd2:    {w_frame[9], w_frame[6], w_frame[3], w_frame[0]} =
                   {r_sync2[0], r_sync2[1], r_sync2[2], r_sync2[3]};
        default: w_frame = r_raw;
      endcase
    end
  end

  always_comb begin
    w_cnt_next = r_stable_cnt;
    if (w_frame != r_prev)
      w_cnt_next = CW'(1);
    else if (r_stable_cnt != CNT_MAX)
      w_cnt_next = r_stable_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_div        <= '0;
      r_col_idx    <= 2'd0;
      r_col        <= 3'b001;
      r_raw        <= '0;
      r_prev       <= '0;
      r_deb        <= '0;
      r_stable_cnt <= '0;
      r_deb_upd    <= 1'b0;
    end else begin
      r_sync1   <= key_row;
      r_sync2   <= r_sync1;
      r_deb_upd <= 1'b0;
      if (w_col_end) begin
        r_div <= '0;
        r_raw <= w_frame;
        if (r_col_idx == 2'd2) begin
          r_col_idx <= 2'd0;
          r_col     <= 3'b001;
        end else begin
          r_col_idx <= r_col_idx + 2'd1;
          r_col     <= {r_col[1:0], 1'b0};
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
      // Debounced pattern only moves on the frame where the run first reaches DEB_SCANS.
      if (w_frame_end) begin
        r_prev       <= w_frame;
        r_stable_cnt <= w_cnt_next;
        if ((w_cnt_next == CNT_MAX) && (r_stable_cnt != CNT_MAX)) begin
          r_deb     <= w_frame;
          r_deb_upd <= 1'b1;
        end
      end
    end
  end

  // key_valid is a one-clock strobe with no backpressure; key_data is stable
  // while it is high and holds until the FSM next changes state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_key_data  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_deb_upd) begin
        case (r_state)
          S_IDLE: begin
            if (w_onehot) begin
              r_state     <= S_PRESSED;
              r_key_data  <= r_deb;
              r_key_valid <= 1'b1;
            end else begin
              r_key_data <= '0;
            end
          end
          S_PRESSED: begin
            if (r_deb == 12'd0) begin
              r_state    <= S_IDLE;
              r_key_data <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign key_col     = r_col;
  assign key_data    = r_key_data;
  assign key_valid   = r_key_valid;
  assign o_fsm_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: matrix model drives rows from key_col; directed
// table, reset sequences and random frame patterns against a frame-level model.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DEB   = 3;
  localparam int FRAME = 3 * SD;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [11:0] key_data;
  logic        key_valid;
  logic        fsm_state;

  logic [11:0] pressed;
  int          vectors;
  int          miscompares;
  int          pulse_cnt;
  int          double_pulse;
  logic        prev_valid;

  keypad_scanner #(.SCAN_DIV(SD), .DEB_SCANS(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_row    (key_row),
    .key_col    (key_col),
    .key_data   (key_data),
    .key_valid  (key_valid),
    .o_fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // key matrix: a pressed key connects its column drive to its row
  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_col[c] && pressed[11 - 3 * r - c]) key_row[r] = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && key_valid) pulse_cnt++;
    if (prev_valid && key_valid) double_pulse++;
    prev_valid = key_valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Leaves the bench #1 after the last reset edge; the next edge is the first
  // scan clock, so frames close every FRAME edges from here.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_window(input logic [11:0] pat, output int pulses);
    int p0;
    pressed = pat;
    p0 = pulse_cnt;
    repeat (FRAME) @(posedge clk);
    #1;
    pulses = pulse_cnt - p0;
  endtask

  // frame-level reference model
  logic [11:0] hist[$];
  logic        m_pressed;
  logic [11:0] m_data;
  logic [11:0] exp_q[$];
  int          exp_p_q[$];

  task automatic model_reset();
    hist.delete();
    m_pressed = 1'b0;
    m_data    = '0;
    exp_q.delete();
    exp_p_q.delete();
    exp_q.push_back(12'h000);
    exp_p_q.push_back(0);
  endtask

  task automatic model_frame(input logic [11:0] f);
    bit upd;
    int pulses;
    hist.push_back(f);
    if (hist.size() > DEB + 1) void'(hist.pop_front());
    upd = 1'b0;
    pulses = 0;
    if (hist.size() >= DEB) begin
      upd = 1'b1;
      for (int i = 1; i <= DEB; i++)
        if (hist[hist.size() - i] != f) upd = 1'b0;
      if (hist.size() > DEB && hist[hist.size() - DEB - 1] == f) upd = 1'b0;
    end
    if (upd) begin
      if (!m_pressed) begin
        if ($countones(f) == 1) begin
          m_pressed = 1'b1;
          m_data    = f;
          pulses    = 1;
        end else begin
          m_data = '0;
        end
      end else if (f == 12'h000) begin
        m_pressed = 1'b0;
        m_data    = '0;
      end
    end
    exp_q.push_back(m_data);
    exp_p_q.push_back(pulses);
  endtask

  typedef struct {
    logic [11:0] keys;
    int          frames;
    int          exp_pulses;
    logic [11:0] exp_data;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int got_p;
    int tot_p;
    int p0;
    int exp_p;
    logic [11:0] exp_d;
    logic [11:0] pat;
    int reps;
    int kind;
    int b0;
    int b1;

    tbl[0]  = '{12'h000, 4, 0, 12'h000};
    tbl[1]  = '{12'h800, 4, 1, 12'h800};
    tbl[2]  = '{12'h000, 4, 0, 12'h000};
    tbl[3]  = '{12'h080, 1, 0, 12'h000};
    tbl[4]  = '{12'h000, 1, 0, 12'h000};
    tbl[5]  = '{12'h080, 1, 0, 12'h000};
    tbl[6]  = '{12'h000, 1, 0, 12'h000};
    tbl[7]  = '{12'h080, 4, 1, 12'h080};
    tbl[8]  = '{12'h000, 4, 0, 12'h000};
    tbl[9]  = '{12'h801, 4, 0, 12'h000};
    tbl[10] = '{12'h000, 4, 0, 12'h000};
    tbl[11] = '{12'h001, 4, 1, 12'h001};
    tbl[12] = '{12'h000, 4, 0, 12'h000};
    tbl[13] = '{12'h400, 4, 1, 12'h400};
    tbl[14] = '{12'h600, 4, 0, 12'h400};
    tbl[15] = '{12'h000, 4, 0, 12'h000};
    tbl[16] = '{12'h200, 4, 1, 12'h200};
    tbl[17] = '{12'h000, 4, 0, 12'h000};

    vectors      = 0;
    miscompares  = 0;
    pulse_cnt    = 0;
    double_pulse = 0;
    prev_valid   = 1'b0;
    pressed      = '0;
    rst_n        = 1'b0;

    @(posedge clk);
    #1;
    apply_reset(2);
    check("reset_key_data", {20'd0, key_data}, 32'h0);
    check("reset_key_valid", {31'd0, key_valid}, 32'h0);
    check("reset_key_col", {29'd0, key_col}, 32'h1);

    // directed table: each row holds a pattern for whole frames
    foreach (tbl[i]) begin
      tot_p = 0;
      for (int f = 0; f < tbl[i].frames; f++) begin
        run_window(tbl[i].keys, got_p);
        tot_p += got_p;
      end
      check($sformatf("row%0d_pulses", i), tot_p, tbl[i].exp_pulses);
      check($sformatf("row%0d_key_data", i), {20'd0, key_data}, {20'd0, tbl[i].exp_data});
    end

    // reset mid-scan, then column sequence
    pressed = '0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midscan_col", {29'd0, key_col}, 32'h1);
    check("midscan_data", {20'd0, key_data}, 32'h0);
    check("midscan_valid", {31'd0, key_valid}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= FRAME; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("col_seq%0d", e), {29'd0, key_col}, 32'(1 << ((e / SD) % 3)));
    end

    // key 11 held through a one-clock reset
    apply_reset(1);
    tot_p = 0;
    for (int f = 0; f < 4; f++) begin
      run_window(12'h002, got_p);
      tot_p += got_p;
    end
    check("k11_first_pulse", tot_p, 1);
    check("k11_first_data", {20'd0, key_data}, 32'h002);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("k11_reset_data", {20'd0, key_data}, 32'h0);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat ((DEB + 1) * FRAME + 4) @(posedge clk);
    #1;
    check("k11_repulse", pulse_cnt - p0, 1);
    check("k11_redata", {20'd0, key_data}, 32'h002);

    // random frame patterns against the model
    pressed = '0;
    apply_reset(2);
    model_reset();
    pat = '0;
    reps = 0;
    for (int k = 0; k < 90; k++) begin
      if (reps == 0) begin
        kind = $urandom_range(0, 9);
        b0 = $urandom_range(0, 11);
        b1 = (b0 + $urandom_range(1, 11)) % 12;
        if (kind < 4)      pat = 12'h000;
        else if (kind < 8) pat = 12'(1 << b0);
        else               pat = 12'((1 << b0) | (1 << b1));
        reps = $urandom_range(1, 5);
      end
      reps--;
      run_window(pat, got_p);
      exp_d = exp_q.pop_front();
      exp_p = exp_p_q.pop_front();
      check($sformatf("rand%0d_pulses", k), got_p, exp_p);
      check($sformatf("rand%0d_key_data", k), {20'd0, key_data}, {20'd0, exp_d});
      model_frame(pat);
    end

    check("no_back_to_back_valid", double_pulse, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
